instr_fetch: RTL

//   Fetch stage between the PC and the Avalon-MM instruction/data memory bus.
//   On each FETCH cycle from the control sequencer, reads the word at the PC address.

---
 rtl/instr_fetch_if.sv | 18 +
 rtl/instr_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Avalon-MM read-only bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_if;
  logic [31:0] avl_address;
  logic        avl_read;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;

  modport master (
    output avl_address, avl_read, avl_byteenable,
    input  avl_waitrequest, avl_readdata
  );

  modport slave (
    input  avl_address, avl_read, avl_byteenable,
    output avl_waitrequest, avl_readdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: one Avalon read per sequencer FETCH, absorbs waitrequest stalls,
// latches the instruction word and tracks sticky halt/fault conditions.
module instr_fetch #(
  parameter int BYTE_SWAP      = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_fetch,
  input  logic [31:0]        i_pc_address,
  input  logic               i_pc_halt,
  instr_fetch_if.master      avl,
  output logic [31:0]        o_instr_word,
  output logic               o_instr_valid,
  output logic               o_stall,
  output logic               o_halted,
  output logic               o_fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_HALT, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_read;
  logic [3:0]       r_be;
  logic [31:0]      r_word;
  logic             r_valid;
  logic             r_halted;
  logic             r_fault;

  logic [31:0]      w_rdata;
  logic             w_legal;
  logic             w_timeout;

  assign w_rdata = (BYTE_SWAP != 0) ?
    {avl.avl_readdata[7:0], avl.avl_readdata[15:8], avl.avl_readdata[23:16], avl.avl_readdata[31:24]} :
    avl.avl_readdata;

  assign w_legal   = i_fetch && !i_pc_halt && (i_pc_address[1:0] == 2'b00);
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_read   <= 1'b0;
      r_be     <= 4'b0000;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_fetch) begin
            if (i_pc_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else if (i_pc_address[1:0] != 2'b00) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_addr  <= i_pc_address;
              r_read  <= 1'b1;
              r_be    <= 4'b1111;
              r_cnt   <= '0;
            end
          end
        end
        S_REQ: begin
          if (!avl.avl_waitrequest) begin
            r_state <= S_DATA;
            r_read  <= 1'b0;
            r_be    <= 4'b0000;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_read  <= 1'b0;
            r_be    <= 4'b0000;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_word  <= w_rdata;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avl.avl_address    = r_addr;
  assign avl.avl_read       = r_read;
  assign avl.avl_byteenable = r_be;

  assign o_instr_word  = r_word;
  assign o_instr_valid = r_valid;
  assign o_halted      = r_halted;
  assign o_fault       = r_fault;
  // The IDLE term is combinational so the sequencer holds FETCH in the same cycle it asks.
  assign o_stall = reset && ((r_state == S_REQ) || (r_state == S_DATA) ||
                             (r_state == S_IDLE && w_legal));

endmodule
